// File: rtl/ysyx_25040129_ifu.sv
// ysyx_25040129_ifu: non-pipelined instruction fetch unit.
//
// Holds the architectural PC and issues one word-aligned read per
// instruction on a request/grant/response port. The fetched word goes to
// decode over a valid/ready handshake. The unit then waits for the next PC
// from execute/writeback before it fetches again.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   mem_req/mem_addr    read request (held until granted) and address (= pc)
//   mem_gnt             request accepted this cycle
//   mem_rvalid/rdata    read response
//   inst_valid/ready    handshake toward decode
//   inst/inst_pc        fetched word and its PC
//   inst_fault          00 none, 01 misaligned PC, 10 bus timeout
//   upd_valid/upd_pc    retire notification carrying the next PC
module ysyx_25040129_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [1:0]  inst_fault,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT);

    localparam logic [1:0] FaultNone     = 2'b00;
    localparam logic [1:0] FaultMisalign = 2'b01;
    localparam logic [1:0] FaultTimeout  = 2'b10;

    typedef enum logic [1:0] {
        StFetch,
        StWait,
        StValid,
        StExec
    } state_e;

    state_e          state_q;
    logic [31:0]     pc_q;
    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_inc;
    logic [31:0]     inst_q;
    logic [31:0]     inst_pc_q;
    logic [1:0]      fault_q;
    logic            valid_q;
    logic            pc_aligned;

    assign pc_aligned = (pc_q[1:0] == 2'b00);

    // Saturating increment of the wait counter.
    assign cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + CntW'(1);

    // A misaligned PC never reaches the bus; it is reported as a fault instead.
    assign mem_req    = (state_q == StFetch) && pc_aligned;
    assign mem_addr   = pc_q;
    assign inst_valid = valid_q;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign inst_fault = fault_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StFetch;
            pc_q      <= RESET_PC;
            cnt_q     <= '0;
            inst_q    <= '0;
            inst_pc_q <= '0;
            fault_q   <= FaultNone;
            valid_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StFetch: begin
                    if (!pc_aligned) begin
                        inst_q    <= '0;
                        inst_pc_q <= pc_q;
                        fault_q   <= FaultMisalign;
                        valid_q   <= 1'b1;
                        state_q   <= StValid;
                    end else if (mem_gnt && mem_rvalid) begin
                        // Zero-latency memory: grant and data in one cycle.
                        inst_q    <= mem_rdata;
                        inst_pc_q <= pc_q;
                        fault_q   <= FaultNone;
                        valid_q   <= 1'b1;
                        state_q   <= StValid;
                    end else if (mem_gnt) begin
                        cnt_q   <= '0;
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    // Data arriving in the last allowed cycle beats the timeout.
                    if (mem_rvalid) begin
                        inst_q    <= mem_rdata;
                        inst_pc_q <= pc_q;
                        fault_q   <= FaultNone;
                        valid_q   <= 1'b1;
                        state_q   <= StValid;
                    end else begin
                        cnt_q <= cnt_inc;
                        if (cnt_inc == CntMax) begin
                            inst_q    <= '0;
                            inst_pc_q <= pc_q;
                            fault_q   <= FaultTimeout;
                            valid_q   <= 1'b1;
                            state_q   <= StValid;
                        end
                    end
                end
                StValid: begin
                    if (inst_ready) begin
                        valid_q <= 1'b0;
                        state_q <= StExec;
                    end
                end
                StExec: begin
                    // inst/inst_pc/inst_fault stay visible while executing.
                    if (upd_valid) begin
                        pc_q    <= upd_pc;
                        state_q <= StFetch;
                    end
                end
                default: state_q <= StFetch;
            endcase
        end
    end

endmodule
